seq_detect_fsm: RTL and testbench

Parametrised serial sequence-detector FSM, generalised from the fixed 2-bit next-state/state-register pairs used in the lab datapaths.
- Detects an arbitrary WIDTH-bit PATTERN on the serial input `a`.
- Overlapping or non-overlapping matching is selectable.
- Counts matches in a saturating counter.
- Provides optional stuck-at fault injection on the next-state vector, for fault-coverage exercises.

---
 rtl/seq_detect_fsm.sv | 94 +++++++++
 tb/tb_seq_detect_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial WIDTH-bit pattern detector (KMP transitions fixed at elaboration) with saturating match counter.
// Define FAULT_INJECT_EN to add stuck-at forcing of one next-state bit.
module seq_detect_fsm #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8,
  parameter int SW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             clear,
  input  logic             fault_en,
  input  logic [SW-1:0]    fault_bit,
  input  logic             fault_val,
  output logic             match,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);
  localparam int NS = 2 ** SW;
  function automatic bit pbit(int i);
    logic [WIDTH-1:0] t;
    t = PATTERN >> i;
    return t[0];
  endfunction
  // Longest suffix of (first k pattern bits, then b) that is a proper prefix of the pattern.
  function automatic int kmp_next(int k, bit b);
    int best;
    int pos;
    bit ok;
    bit c;
    best = 0;
    for (int l = 1; l < WIDTH; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          pos = k + 1 - l + j;
          c = (pos == k) ? b : pbit(WIDTH - 1 - pos);
          if (c != pbit(WIDTH - 1 - j)) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  genvar s;
  for (s = 0; s < NS; s++) begin : g_tab
    localparam int N0 = (s < WIDTH) ? kmp_next(s, 1'b0) : 0;
    localparam int N1 = (s < WIDTH) ? kmp_next(s, 1'b1) : 0;
    assign nxt0[s] = SW'(N0);
    assign nxt1[s] = SW'(N1);
  end
  logic [SW-1:0]    state_q, state_d, raw_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             legal, hit;
`ifdef FAULT_INJECT_EN
  logic [SW-1:0]    mask;
`else
  logic             unused_fault;
  assign unused_fault = ^{fault_en, fault_bit, fault_val};
`endif
  always_comb begin
    legal = {1'b0, state_q} < (SW + 1)'(WIDTH);
    hit = en && legal && state_q == SW'(WIDTH - 1) && a == PATTERN[0];
    raw_d = !legal ? '0 : !en ? state_q : (hit && !OVERLAP) ? '0 : a ? nxt1[state_q] : nxt0[state_q];
`ifdef FAULT_INJECT_EN
    mask = fault_en ? SW'(1) << fault_bit : '0;
    state_d = (raw_d & ~mask) | ({SW{fault_val}} & mask);
`else
    state_d = raw_d;
`endif
    match_d = hit;
    cnt_d = clear ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= '0;
      match_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cnt_q <= cnt_d;
    end
  end
  assign state = state_q;
  assign match = match_q;
  assign match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: six detector configurations checked against a history-based reference model.
module tb_seq_detect_fsm;
  logic clock = 0, reset = 1, en = 0, a = 0, clear = 0;
  logic fault_en = 0, fault_val = 0;
  logic [1:0] fault_bit = 0;
  logic [1:0] st_o [6];
  logic m_o [6];
  logic [7:0] cnt_o [6];
  logic [1:0] cnt4;
  assign cnt_o[4] = {6'b0, cnt4};
  always #5 clock = ~clock;

  seq_detect_fsm #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[0]), .state(st_o[0]), .match_count(cnt_o[0]));
  seq_detect_fsm #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[1]), .state(st_o[1]), .match_count(cnt_o[1]));
  seq_detect_fsm #(.WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) d2 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[2]), .state(st_o[2]), .match_count(cnt_o[2]));
  seq_detect_fsm #(.WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) d3 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[3]), .state(st_o[3]), .match_count(cnt_o[3]));
  seq_detect_fsm #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d4 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[4]), .state(st_o[4]), .match_count(cnt4));
  seq_detect_fsm #(.WIDTH(3), .PATTERN(3'b110), .OVERLAP(1'b1), .CNT_W(8)) d5 (.clock(clock), .reset(reset), .en(en), .a(a), .clear(clear),
    .fault_en(fault_en), .fault_bit(fault_bit), .fault_val(fault_val), .match(m_o[5]), .state(st_o[5]), .match_count(cnt_o[5]));

  // Model: keep the consumed bit history; state and match follow directly from string comparison.
  int mw [6] = '{4, 4, 4, 4, 4, 3};
  int mpat [6] = '{11, 11, 10, 10, 11, 6};
  bit mov [6] = '{1, 0, 1, 0, 1, 1};
  int mcw [6] = '{8, 8, 8, 8, 2, 8};
  logic [31:0] mh [6];
  int mn [6];
  int mc [6];
  bit mm [6];
  bit model_ok = 1;
  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit mhit(int i);
    return mn[i] >= mw[i] && ((mh[i] & ((32'd1 << mw[i]) - 32'd1)) == 32'(mpat[i]));
  endfunction

  function automatic int mstate(int i);
    int best = 0;
    for (int l = 1; l < mw[i]; l++)
      if (l <= mn[i] && ((mh[i] & ((32'd1 << l) - 32'd1)) == (32'(mpat[i]) >> (mw[i] - l)))) best = l;
    return best;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 6; i++) begin
      if (reset) begin
        mh[i] = 0; mn[i] = 0; mc[i] = 0; mm[i] = 0;
      end else begin
        mm[i] = 0;
        if (en) begin
          mh[i] = {mh[i][30:0], a};
          if (mn[i] < 32) mn[i]++;
          if (mhit(i)) begin
            mm[i] = 1;
            if (!mov[i]) mn[i] = 0;
          end
        end
        if (clear) mc[i] = 0;
        else if (mm[i] && mc[i] < (1 << mcw[i]) - 1) mc[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (model_ok)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("d%0d state", i), int'(st_o[i]), mstate(i));
        chk($sformatf("d%0d match", i), int'(m_o[i]), int'(mm[i]));
        chk($sformatf("d%0d count", i), int'(cnt_o[i]), mc[i]);
      end
  endtask

  task automatic drive(bit r, bit e, bit av, bit c);
    reset = r; en = e; a = av; clear = c;
    tick();
  endtask

  typedef struct {bit r, e, av, c; int st, m, cnt;} vec_t;
  vec_t tv [15];

  initial begin
    logic [6:0] sa;
    logic [5:0] sb;
    logic [3:0] p4;
    logic [2:0] p3;
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 1, 0, 1, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 2, 0, 0};
    tv[3]  = '{0, 1, 1, 0, 3, 0, 0};
    tv[4]  = '{0, 1, 1, 0, 1, 1, 1};
    tv[5]  = '{1, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 1, 1, 0, 1, 0, 0};
    tv[7]  = '{0, 1, 0, 0, 2, 0, 0};
    tv[8]  = '{0, 0, 0, 0, 2, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 2, 0, 0};
    tv[10] = '{0, 0, 0, 0, 2, 0, 0};
    tv[11] = '{0, 1, 1, 0, 3, 0, 0};
    tv[12] = '{0, 1, 1, 0, 1, 1, 1};
    tv[13] = '{0, 1, 0, 1, 2, 0, 0};
    tv[14] = '{1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].r, tv[i].e, tv[i].av, tv[i].c);
      chk($sformatf("tbl%0d state", i), int'(st_o[0]), tv[i].st);
      chk($sformatf("tbl%0d match", i), int'(m_o[0]), tv[i].m);
      chk($sformatf("tbl%0d count", i), int'(cnt_o[0]), tv[i].cnt);
    end
    // overlap vs non-overlap on two streams
    sa = 7'b1011011;
    drive(1, 0, 0, 0);
    for (int j = 0; j < 7; j++) begin
      drive(0, 1, sa[6 - j], 0);
      chk("ovl pulse", int'(m_o[0]), int'(j == 3 || j == 6));
    end
    chk("streamA d0", int'(cnt_o[0]), 2);
    chk("streamA d1", int'(cnt_o[1]), 1);
    chk("streamA d2", int'(cnt_o[2]), 0);
    sb = 6'b101010;
    drive(1, 0, 0, 0);
    for (int j = 0; j < 6; j++) drive(0, 1, sb[5 - j], 0);
    chk("streamB d2", int'(cnt_o[2]), 2);
    chk("streamB d3", int'(cnt_o[3]), 1);
    chk("streamB d0", int'(cnt_o[0]), 0);
    // five back-to-back overlapping matches: 2-bit counter saturates
    drive(1, 0, 0, 0);
    p4 = 4'b1011;
    p3 = 3'b011;
    for (int r = 0; r < 5; r++) begin
      if (r == 0) for (int j = 0; j < 4; j++) drive(0, 1, p4[3 - j], 0);
      else for (int j = 0; j < 3; j++) drive(0, 1, p3[2 - j], 0);
      chk("sat match", int'(m_o[4]), 1);
      chk("sat count", int'(cnt4), r < 3 ? r + 1 : 3);
    end
    chk("pre-clear count", int'(cnt_o[0]), 5);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 1);
    chk("clear prio match", int'(m_o[0]), 1);
    chk("clear prio count", int'(cnt_o[0]), 0);
`ifdef FAULT_INJECT_EN
    drive(1, 0, 0, 0);
    model_ok = 0;
    fault_en = 1; fault_bit = 0; fault_val = 0;
    for (int j = 0; j < 4; j++) begin
      drive(0, 1, p4[3 - j], 0);
      chk("fault state", int'(st_o[0] == 2'd0 || st_o[0] == 2'd2), 1);
      chk("fault match", int'(m_o[0]), 0);
    end
    fault_en = 0;
    drive(1, 0, 0, 0);
    model_ok = 1;
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    chk("pre-reset state", int'(st_o[0]), 2);
    drive(1, 1, 1, 0);
    chk("mid reset state", int'(st_o[0]), 0);
`endif
    drive(1, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
`ifndef FAULT_INJECT_EN
      fault_en = 1'($urandom);
      fault_bit = 2'($urandom);
      fault_val = 1'($urandom);
`endif
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
